// File: rtl/frame_irq_scheduler_if.sv
//----------------------------------------------------------------------------
// Module : frame_irq_scheduler_if
// Brief  : Observed Avalon-ST video beat signals plus the processing gate.
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface frame_irq_scheduler_if;
  logic vid_valid;
  logic vid_ready;
  logic vid_sop;
  logic vid_eop;
  logic gate_open;

  modport master (
    output vid_valid,
    output vid_ready,
    output vid_sop,
    output vid_eop,
    input  gate_open
  );

  modport slave (
    input  vid_valid,
    input  vid_ready,
    input  vid_sop,
    input  vid_eop,
    output gate_open
  );
endinterface

`default_nettype wire

// File: rtl/frame_irq_scheduler.sv
//----------------------------------------------------------------------------
// Module : frame_irq_scheduler
// Brief  : Gates whole decimated video frames and raises a status interrupt.
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module frame_irq_scheduler #(
  parameter int DECIM_W        = 4,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  frame_irq_scheduler_if.slave vid,
  input  logic                 enable,
  input  logic [DECIM_W-1:0]   decim,
  input  logic                 irq_ack,
  output logic                 irq,
  output logic [1:0]           status,
  output logic [15:0]          frame_count,
  output logic                 busy
);

  localparam int              c_cnt_w   = 24;
  localparam logic [c_cnt_w-1:0] c_timeout = 24'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOP = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_SKIP     = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DECIM_W-1:0]   r_skip_cnt;
  logic [DECIM_W-1:0]   w_skip_nxt;
  logic [c_cnt_w-1:0]   r_idle_cnt;
  logic                 r_irq;
  logic [1:0]           r_status;
  logic [15:0]          r_frame_count;

  logic w_beat;
  logic w_sop_beat;
  logic w_eop_beat;
  logic w_in_frame;
  logic w_timeout;
  logic w_done;
  logic w_error;
  logic w_gate;

  assign w_beat     = vid.vid_valid & vid.vid_ready;
  assign w_sop_beat = w_beat & vid.vid_sop;
  assign w_eop_beat = w_beat & vid.vid_eop;
  assign w_in_frame = (r_state == ST_ACTIVE) || (r_state == ST_SKIP);
  assign w_timeout  = w_in_frame && (r_idle_cnt == c_timeout);

  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip_cnt;
    w_done      = 1'b0;
    w_error     = 1'b0;
    w_gate      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_skip_nxt = '0;
        if (enable) w_state_nxt = ST_WAIT_SOP;
      end
      ST_WAIT_SOP: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sop_beat) begin
          if (r_skip_cnt == '0) begin
            w_gate     = 1'b1;
            w_skip_nxt = decim;
            // A sop+eop beat is a complete one-beat frame; stay here.
            if (w_eop_beat) w_done = 1'b1;
            else            w_state_nxt = ST_ACTIVE;
          end else begin
            w_skip_nxt = r_skip_cnt - DECIM_W'(1);
            if (!w_eop_beat) w_state_nxt = ST_SKIP;
          end
        end
      end
      ST_ACTIVE: begin
        w_gate = !w_sop_beat;
        if (w_timeout) begin
          w_error     = 1'b1;
          w_state_nxt = enable ? ST_WAIT_SOP : ST_IDLE;
        end else if (w_sop_beat) begin
          w_error     = 1'b1;
          w_state_nxt = ST_WAIT_SOP;
        end else if (w_eop_beat) begin
          w_done      = 1'b1;
          w_state_nxt = enable ? ST_WAIT_SOP : ST_IDLE;
        end
      end
      ST_SKIP: begin
        if (w_timeout) begin
          w_error     = 1'b1;
          w_state_nxt = enable ? ST_WAIT_SOP : ST_IDLE;
        end else if (w_sop_beat) begin
          w_error     = 1'b1;
          w_state_nxt = ST_WAIT_SOP;
        end else if (w_eop_beat) begin
          w_state_nxt = enable ? ST_WAIT_SOP : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_skip_cnt    <= '0;
      r_idle_cnt    <= '0;
      r_irq         <= 1'b0;
      r_status      <= 2'b00;
      r_frame_count <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_skip_cnt <= w_skip_nxt;

      if (w_in_frame && !w_beat && !w_timeout) r_idle_cnt <= r_idle_cnt + 24'd1;
      else                                     r_idle_cnt <= '0;

      if (w_done) r_frame_count <= r_frame_count + 16'd1;

      // A new event outranks a same-cycle ack: status restarts from that event.
      if (w_done || w_error) begin
        r_irq <= 1'b1;
        if (irq_ack) r_status <= {w_error, w_done};
        else         r_status <= {r_status[1] | w_error | (w_done & r_irq),
                                  r_status[0] | w_done};
      end else if (irq_ack) begin
        r_irq    <= 1'b0;
        r_status <= 2'b00;
      end
    end
  end

  assign vid.gate_open = w_gate;
  assign irq           = r_irq;
  assign status        = r_status;
  assign frame_count   = r_frame_count;
  assign busy          = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_frame_irq_scheduler.sv
//----------------------------------------------------------------------------
// Module : tb_frame_irq_scheduler
// Brief  : Self-checking bench with a gate scoreboard for frame_irq_scheduler.
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_frame_irq_scheduler;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  decim;
  logic        irq_ack;
  logic        irq;
  logic [1:0]  status;
  logic [15:0] frame_count;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  bit gate_q[$];

  frame_irq_scheduler_if vif ();

  frame_irq_scheduler #(
    .DECIM_W        (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vid         (vif),
    .enable      (enable),
    .decim       (decim),
    .irq_ack     (irq_ack),
    .irq         (irq),
    .status      (status),
    .frame_count (frame_count),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every accepted beat pops the gate value pushed when it was driven.
  always @(negedge clk) begin
    if (!reset && vif.vid_valid && vif.vid_ready) begin
      if (gate_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL gate_unexpected_beat observed=%0b expected=none", vif.gate_open);
      end else begin
        check_eq("gate_open", 32'(vif.gate_open), 32'(gate_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    vif.vid_valid = 1'b0;
    vif.vid_sop   = 1'b0;
    vif.vid_eop   = 1'b0;
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    #1;
  endtask

  task automatic send_beats(input int n, input bit sop_first, input bit eop_last,
                            input bit exp_gate, input int drop_en_at, input bit ack_at_eop);
    for (int i = 0; i < n; i++) begin
      vif.vid_valid = 1'b1;
      vif.vid_ready = 1'b1;
      vif.vid_sop   = sop_first && (i == 0);
      vif.vid_eop   = eop_last && (i == n - 1);
      if (i == drop_en_at) enable = 1'b0;
      irq_ack = ack_at_eop && (i == n - 1);
      gate_q.push_back(exp_gate);
      tick();
    end
    idle_bus();
    irq_ack = 1'b0;
  endtask

  task automatic send_onebeats(input int n);
    for (int i = 0; i < n; i++) begin
      vif.vid_valid = 1'b1;
      vif.vid_ready = 1'b1;
      vif.vid_sop   = 1'b1;
      vif.vid_eop   = 1'b1;
      gate_q.push_back(1'b1);
      tick();
    end
    idle_bus();
  endtask

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    decim         = 4'd0;
    irq_ack       = 1'b0;
    vif.vid_ready = 1'b1;
    idle_bus();
    repeat (3) tick();
    #1;
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_status", 32'(status), 32'd0);
    check_eq("rst_frame_count", 32'(frame_count), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_gate", 32'(vif.gate_open), 32'd0);
    tick();
    reset = 1'b0;

    // Decimation by 3: frames 0 and 3 selected
    decim  = 4'd2;
    enable = 1'b1;
    tick(); #1;
    check_eq("busy_after_enable", 32'(busy), 32'd1);
    send_beats(10, 1, 1, 1, -1, 0); #1;
    check_eq("f0_irq", 32'(irq), 32'd1);
    check_eq("f0_status", 32'(status), 32'd1);
    check_eq("f0_count", 32'(frame_count), 32'd1);
    ack_pulse();
    check_eq("ack_irq", 32'(irq), 32'd0);
    check_eq("ack_status", 32'(status), 32'd0);
    send_beats(10, 1, 1, 0, -1, 0);
    send_beats(10, 1, 1, 0, -1, 0); #1;
    check_eq("skip_no_irq", 32'(irq), 32'd0);
    send_beats(10, 1, 1, 1, -1, 0); #1;
    check_eq("f3_irq", 32'(irq), 32'd1);
    check_eq("f3_status", 32'(status), 32'd1);
    send_beats(10, 1, 1, 0, -1, 0);
    send_beats(10, 1, 1, 0, -1, 0); #1;
    check_eq("decim_count", 32'(frame_count), 32'd2);

    // Overrun, then ack coincident with eop
    decim = 4'd0;
    send_beats(10, 1, 1, 1, -1, 0); #1;
    check_eq("overrun_status", 32'(status), 32'd3);
    check_eq("overrun_count", 32'(frame_count), 32'd3);
    ack_pulse();
    check_eq("ack2_status", 32'(status), 32'd0);
    send_beats(10, 1, 1, 1, -1, 0);
    send_beats(10, 1, 1, 1, -1, 1); #1;
    check_eq("ack_eop_irq", 32'(irq), 32'd1);
    check_eq("ack_eop_status", 32'(status), 32'd1);
    check_eq("ack_eop_count", 32'(frame_count), 32'd5);
    ack_pulse();

    // Enable dropped during beat 5 of a selected frame
    send_beats(10, 1, 1, 1, 4, 0); #1;
    check_eq("drop_irq", 32'(irq), 32'd1);
    check_eq("drop_status", 32'(status), 32'd1);
    check_eq("drop_busy", 32'(busy), 32'd0);
    check_eq("drop_count", 32'(frame_count), 32'd6);
    send_beats(10, 1, 1, 0, -1, 0); #1;
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_count", 32'(frame_count), 32'd6);
    ack_pulse();

    // Timeout after beat 3 of a selected frame
    enable = 1'b1;
    tick(); #1;
    check_eq("reenable_busy", 32'(busy), 32'd1);
    send_beats(3, 1, 0, 1, -1, 0);
    repeat (100) tick();
    #1;
    check_eq("pre_timeout_irq", 32'(irq), 32'd0);
    check_eq("pre_timeout_gate", 32'(vif.gate_open), 32'd1);
    tick(); #1;
    check_eq("timeout_irq", 32'(irq), 32'd1);
    check_eq("timeout_status", 32'(status), 32'd2);
    check_eq("timeout_gate", 32'(vif.gate_open), 32'd0);
    check_eq("timeout_busy", 32'(busy), 32'd1);
    ack_pulse();

    // Missing eop: second sop mid-frame is not gated nor restarted
    send_beats(4, 1, 0, 1, -1, 0);
    send_beats(1, 1, 0, 0, -1, 0);
    send_beats(3, 0, 1, 0, -1, 0); #1;
    check_eq("noeop_irq", 32'(irq), 32'd1);
    check_eq("noeop_status", 32'(status), 32'd2);
    check_eq("noeop_count", 32'(frame_count), 32'd6);
    ack_pulse();

    // One-beat frames and frame_count wrap
    send_beats(1, 1, 1, 1, -1, 0); #1;
    check_eq("onebeat_irq", 32'(irq), 32'd1);
    check_eq("onebeat_status", 32'(status), 32'd1);
    check_eq("onebeat_count", 32'(frame_count), 32'd7);
    ack_pulse();
    send_onebeats(65528); #1;
    check_eq("count_max", 32'(frame_count), 32'd65535);
    send_onebeats(1); #1;
    check_eq("count_wrap", 32'(frame_count), 32'd0);
    check_eq("wrap_status", 32'(status), 32'd3);

    tick();
    check_eq("gate_q_drained", 32'(gate_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_irq_scheduler.md
# frame_irq_scheduler

Frame-level scheduler between the camera video stream and the Nios II software. It watches start-of-packet and end-of-packet beats on the Avalon-ST video path and opens a processing gate only on whole, selected frames, with selection by software-programmed decimation. When a selected frame completes, it raises a level interrupt with a 2-bit status word that the software's EOP PIO reads. It also detects stalled and malformed frames.

## Interface
Parameters:
- DECIM_W, 4, width of the decimation setting; processes 1 of every decim+1 frames.
- TIMEOUT_CYCLES, 5000000, maximum idle cycles inside a frame before the frame is aborted; range 1 to 2^24-1.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- vid_valid  in  1  stream valid, observed.
- vid_ready  in  1  stream ready, observed. A beat is vid_valid & vid_ready.
- vid_sop  in  1  start-of-packet, qualified by beat.
- vid_eop  in  1  end-of-packet, qualified by beat.
- enable  in  1  software enable; takes effect only at frame boundaries.
- decim  in  DECIM_W  decimation setting; sampled on each accepted SOP.
- irq_ack  in  1  single-cycle pulse from software; clears irq and status.
- gate_open  out  1  combinational; high on beats that belong to a selected frame.
- irq  out  1  registered interrupt level.
- status  out  2  registered, sticky. [0] = frame done; [1] = error (overrun, timeout or missing EOP).
- frame_count  out  16  number of completed selected frames; wraps from 65535 to 0.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has four states: IDLE, WAIT_SOP, ACTIVE, SKIP.
- IDLE:
  - skip_cnt is forced to 0.
  - If enable = 1, go to WAIT_SOP.
- WAIT_SOP:
  - If enable = 0, go to IDLE.
  - On a beat with sop and skip_cnt = 0: go to ACTIVE and load skip_cnt with decim.
  - On a beat with sop and skip_cnt ≠ 0: go to SKIP and decrement skip_cnt.
  - A sop that arrives together with eop is a one-beat frame. It is completed in the same cycle and the FSM stays in WAIT_SOP. If the frame is selected, it raises a done event.
  - Non-sop beats are ignored.
- ACTIVE:
  - An eop beat raises a done event and increments frame_count.
  - The next state after eop is WAIT_SOP if enable = 1, otherwise IDLE.
- SKIP:
  - An eop beat goes to WAIT_SOP if enable = 1, otherwise IDLE. It raises no event.
- Missing EOP: a sop beat while in ACTIVE or SKIP raises an error event and goes to WAIT_SOP. That sop beat is not gated and is not re-evaluated.
- Timeout: while in ACTIVE or SKIP, a counter counts consecutive cycles without a beat.
  - Any beat clears the counter.
  - When the counter reaches TIMEOUT_CYCLES, raise an error event and go to WAIT_SOP (or IDLE if enable = 0).
  - The counter is 0 in every other state.
- gate_open is high in either case:
  - state = ACTIVE and not (beat & sop);
  - state = WAIT_SOP & enable & beat & sop & skip_cnt = 0.
- Events:
  - A done event sets status[0] and irq.
  - An error event sets status[1] and irq.
  - A done event while irq is already 1 and no ack is present is an overrun: it sets status[0] and status[1].
- irq_ack:
  - On the next cycle, irq = 0 and status = 0.
  - If an event occurs in the same cycle as the ack, the event wins: irq stays 1 and status holds only the new event's bits.
- Dropping enable while in ACTIVE lets the current frame finish and report. No partial frame is ever gated.

## Timing
- Reset values: state IDLE, gate_open 0, irq 0, status 2'b00, frame_count 0, busy 0, skip_cnt 0, timeout counter 0.
- Reset asserted mid-frame returns the block to IDLE on the next edge. A pending irq is lost.
- State, irq, status and frame_count update on the edge after the triggering beat. irq latency from the eop beat is 1 cycle.
- gate_open has zero latency; it is combinational from the beat inputs.
- busy is 1 from the cycle after enable is seen in IDLE.
- decim is sampled only on an accepted sop in WAIT_SOP. Changes mid-frame have no effect on that frame.
- Timeout fires in the cycle the counter equals TIMEOUT_CYCLES. The state changes on the following edge.

## Test plan
- Decimation: decim = 2, enable = 1, six 10-beat frames → frames 0 and 3 gated, 1/2/4/5 not; frame_count = 2; irq 1 cycle after eop of frame 0 and of frame 3.
- Ack and overrun:
  - Frame completes, no ack, second selected frame completes → status = 2'b11.
  - irq_ack → irq = 0, status = 0 next cycle.
  - Ack coincident with an eop → irq stays 1, status = 2'b01.
- Mid-frame enable: enable falls during beat 5 of a selected frame → frame fully gated, done reported, next state IDLE, busy = 0. Next frame's sop not gated.
- Timeout: TIMEOUT_CYCLES = 100; vid_valid held low for 100 cycles after beat 3 of a selected frame → status = 2'b10, irq = 1, gate_open = 0, state returns to WAIT_SOP.
- Missing EOP: sop while in ACTIVE → status[1] = 1; that beat gate_open = 0.
- One-beat frame: sop & eop on a single beat (decim = 0) → gate_open = 1 for that beat; done next cycle; frame_count wraps 65535 → 0 when preloaded by repetition.
